// File: rtl/pulse_peak_finder.sv
// rtl/pulse_peak_finder.sv - threshold pulse detector emitting peak amplitude, time and width events
// One-entry output register with saturating drop counter; all outputs registered.
module pulse_peak_finder #(
  parameter int                       DATA_W    = 16,
  parameter int                       TS_W      = 32,
  parameter logic signed [DATA_W-1:0] THRESHOLD = 100,
  parameter int                       HOLDOFF   = 4,
  parameter int                       WIDTH_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] peak_value,
  output logic [TS_W-1:0]          peak_time,
  output logic [WIDTH_W-1:0]       peak_width,
  output logic                     pileup,
  output logic [15:0]              dropped_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [7:0]         HOLD_CNT  = 8'(HOLDOFF);
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

  state_t                     state_q;
  logic [TS_W-1:0]            ts_q, ts_d;
  logic signed [DATA_W-1:0]   max_q;
  logic [TS_W-1:0]            max_ts_q;
  logic [WIDTH_W-1:0]         width_q, width_d;
  logic [7:0]                 cnt_q;

  logic                       out_valid_q;
  logic signed [DATA_W-1:0]   peak_value_q;
  logic [TS_W-1:0]            peak_time_q;
  logic [WIDTH_W-1:0]         peak_width_q;
  logic                       pileup_q;
  logic [15:0]                dropped_q, dropped_d;

  logic above;
  logic emit;
  logic load;

  always_comb begin
    above     = filter_data > THRESHOLD;
    emit      = (state_q == S_RISE) && !above;
    // A full register still accepts when it is being read on the same edge.
    load      = emit && (!out_valid_q || out_ready);
    ts_d      = ts_q + 1'b1;
    width_d   = (width_q == WIDTH_MAX) ? width_q : width_q + 1'b1;
    dropped_d = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      max_q        <= '0;
      max_ts_q     <= '0;
      width_q      <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      peak_value_q <= '0;
      peak_time_q  <= '0;
      peak_width_q <= '0;
      pileup_q     <= 1'b0;
      dropped_q    <= '0;
    end else begin
      ts_q <= ts_d;

      case (state_q)
        S_IDLE: begin
          if (above) begin
            max_q    <= filter_data;
            max_ts_q <= ts_q;
            width_q  <= {{(WIDTH_W-1){1'b0}}, 1'b1};
            state_q  <= S_RISE;
          end
        end
        S_RISE: begin
          if (above) begin
            width_q <= width_d;
            // Strict compare: a flat top keeps the timestamp of its first sample.
            if (filter_data > max_q) begin
              max_q    <= filter_data;
              max_ts_q <= ts_q;
            end
          end else begin
            cnt_q   <= HOLD_CNT;
            state_q <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (load) begin
        out_valid_q  <= 1'b1;
        peak_value_q <= max_q;
        peak_time_q  <= max_ts_q;
        peak_width_q <= width_q;
        pileup_q     <= (width_q == WIDTH_MAX);
      end else begin
        if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
        end
        if (emit) begin
          dropped_q <= dropped_d;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign peak_value  = peak_value_q;
  assign peak_time   = peak_time_q;
  assign peak_width  = peak_width_q;
  assign pileup      = pileup_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_pulse_peak_finder.sv
// tb/tb_pulse_peak_finder.sv - directed scoreboard bench for pulse_peak_finder
module tb_pulse_peak_finder;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] filter_data;
  logic               out_ready;
  logic               out_valid;
  logic signed [15:0] peak_value;
  logic [31:0]        peak_time;
  logic [7:0]         peak_width;
  logic               pileup;
  logic [15:0]        dropped_cnt;

  logic signed [15:0] data8;
  logic               out_ready8;
  logic               out_valid8;
  logic signed [15:0] peak_value8;
  logic [7:0]         peak_time8;
  logic [7:0]         peak_width8;
  logic               pileup8;
  logic [15:0]        dropped_cnt8;

  typedef struct {
    logic [15:0] val;
    logic [31:0] tim;
    logic [7:0]  wid;
    logic        pu;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  ts_m  = 0;
  int  a_ts, b_ts, c_ts, t0;

  always #5 clk = ~clk;

  pulse_peak_finder dut (
    .clk(clk), .reset(reset), .filter_data(filter_data), .out_ready(out_ready),
    .out_valid(out_valid), .peak_value(peak_value), .peak_time(peak_time),
    .peak_width(peak_width), .pileup(pileup), .dropped_cnt(dropped_cnt)
  );

  pulse_peak_finder #(.TS_W(8)) dut8 (
    .clk(clk), .reset(reset), .filter_data(data8), .out_ready(out_ready8),
    .out_valid(out_valid8), .peak_value(peak_value8), .peak_time(peak_time8),
    .peak_width(peak_width8), .pileup(pileup8), .dropped_cnt(dropped_cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ts_m is the timestamp the next edge will carry.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset) ts_m = 0;
    else ts_m++;
  endtask

  task automatic step(input logic signed [15:0] d);
    filter_data = d;
    tick();
  endtask

  task automatic check_event(input string tag, input logic v, input logic [15:0] val,
                             input logic [31:0] tim, input logic [7:0] wid, input logic pu);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=event expected=none_queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(v), 32'd1);
      chk({tag, "_value"}, 32'(val), 32'(e.val));
      chk({tag, "_time"}, tim, e.tim);
      chk({tag, "_width"}, 32'(wid), 32'(e.wid));
      chk({tag, "_pileup"}, 32'(pu), 32'(e.pu));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; filter_data = '0; out_ready = 1'b0; data8 = '0; out_ready8 = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_value", 32'(peak_value), 32'd0);
    chk("rst_time", peak_time, 32'd0);
    chk("rst_width", 32'(peak_width), 32'd0);
    chk("rst_pileup", 32'(pileup), 32'd0);
    chk("rst_dropped", 32'(dropped_cnt), 32'd0);
    chk("rst_valid8", 32'(out_valid8), 32'd0);

    // Basic pulse
    while (ts_m < 10) step(16'sd0);
    step(16'sd50); step(16'sd150); step(16'sd300); step(16'sd420); step(16'sd420); step(16'sd380);
    chk("basic_pre", 32'(out_valid), 32'd0);
    sb.push_back('{16'd420, 32'd13, 8'd5, 1'b0});
    step(16'sd90);
    check_event("basic", out_valid, peak_value, peak_time, peak_width, pileup);

    // Holdoff swallows samples 17..20
    repeat (4) step(16'sd200);
    repeat (10) step(16'sd0);
    chk("hold_dropped", 32'(dropped_cnt), 32'd0);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_value", 32'(peak_value), 32'd420);
    out_ready = 1'b1; step(16'sd0); out_ready = 1'b0;
    chk("hold_pop", 32'(out_valid), 32'd0);

    // Holdoff end: sample at ts 21 starts a new pulse
    reset = 1'b0; step(16'sd0); reset = 1'b1;
    while (ts_m < 10) step(16'sd0);
    sb.push_back('{16'd420, 32'd13, 8'd5, 1'b0});
    step(16'sd50); step(16'sd150); step(16'sd300); step(16'sd420); step(16'sd420); step(16'sd380);
    step(16'sd90);
    check_event("basic2", out_valid, peak_value, peak_time, peak_width, pileup);
    out_ready = 1'b1; step(16'sd0); out_ready = 1'b0;
    chk("basic2_pop", 32'(out_valid), 32'd0);
    repeat (3) step(16'sd0);
    step(16'sd200);
    sb.push_back('{16'd200, 32'd21, 8'd1, 1'b0});
    step(16'sd0);
    check_event("hold_end", out_valid, peak_value, peak_time, peak_width, pileup);
    out_ready = 1'b1; step(16'sd0); out_ready = 1'b0;

    // Backpressure
    repeat (6) step(16'sd0);
    a_ts = ts_m;
    step(16'sd300);
    sb.push_back('{16'd300, 32'(a_ts), 8'd1, 1'b0});
    step(16'sd0);
    check_event("bp_first", out_valid, peak_value, peak_time, peak_width, pileup);
    repeat (8) step(16'sd0);
    step(16'sd500);
    step(16'sd0);
    repeat (3) step(16'sd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_value", 32'(peak_value), 32'd300);
    chk("bp_time", peak_time, 32'(a_ts));
    chk("bp_dropped", 32'(dropped_cnt), 32'd1);
    out_ready = 1'b1; step(16'sd0); out_ready = 1'b0;
    chk("bp_pop", 32'(out_valid), 32'd0);

    // Simultaneous pop and push
    repeat (6) step(16'sd0);
    b_ts = ts_m;
    step(16'sd250);
    sb.push_back('{16'd250, 32'(b_ts), 8'd1, 1'b0});
    step(16'sd0);
    check_event("sim_a", out_valid, peak_value, peak_time, peak_width, pileup);
    repeat (6) step(16'sd0);
    c_ts = ts_m;
    step(16'sd350);
    sb.push_back('{16'd350, 32'(c_ts), 8'd1, 1'b0});
    out_ready = 1'b1;
    step(16'sd0);
    check_event("sim_b", out_valid, peak_value, peak_time, peak_width, pileup);
    chk("sim_dropped", 32'(dropped_cnt), 32'd1);
    step(16'sd0);
    chk("sim_pop", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Pile-up and sign
    repeat (6) step(16'sd0);
    repeat (20) step(16'sh8000);
    chk("neg_no_event", 32'(out_valid), 32'd0);
    t0 = ts_m;
    repeat (300) step(16'sd1000);
    sb.push_back('{16'd1000, 32'(t0), 8'd255, 1'b1});
    step(16'sd0);
    check_event("pileup", out_valid, peak_value, peak_time, peak_width, pileup);

    // Reset mid-pulse
    repeat (6) step(16'sd0);
    repeat (3) step(16'sd300);
    reset = 1'b0; step(16'sd0); reset = 1'b1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_value", 32'(peak_value), 32'd0);
    chk("mid_time", peak_time, 32'd0);
    chk("mid_width", 32'(peak_width), 32'd0);
    chk("mid_pileup", 32'(pileup), 32'd0);
    chk("mid_dropped", 32'(dropped_cnt), 32'd0);
    step(16'sd0); step(16'sd0);
    chk("mid_no_event", 32'(out_valid), 32'd0);
    step(16'sd200);
    sb.push_back('{16'd200, 32'd2, 8'd1, 1'b0});
    step(16'sd0);
    check_event("ts_restart", out_valid, peak_value, peak_time, peak_width, pileup);
    out_ready = 1'b1; step(16'sd0); out_ready = 1'b0;

    // Timestamp wrap on the 8-bit instance
    while ((ts_m % 256) != 254) step(16'sd0);
    data8 = 16'sd200; tick();
    data8 = 16'sd300; tick();
    data8 = 16'sd0;
    sb.push_back('{16'd300, 32'd255, 8'd2, 1'b0});
    tick();
    check_event("wrap", out_valid8, peak_value8, {24'd0, peak_time8}, peak_width8, pileup8);
    out_ready8 = 1'b1;
    repeat (4) tick();
    out_ready8 = 1'b0;
    chk("wrap_pop", 32'(out_valid8), 32'd0);
    data8 = 16'sd150; tick();
    data8 = 16'sd0;
    sb.push_back('{16'd150, 32'd5, 8'd1, 1'b0});
    tick();
    check_event("wrap_after", out_valid8, peak_value8, {24'd0, peak_time8}, peak_width8, pileup8);
    chk("wrap_dropped", 32'(dropped_cnt8), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_peak_finder.md
# pulse_peak_finder

Downstream consumer of the trapezoidal shaping filter output. Watches the signed filtered stream for threshold crossings, tracks each pulse's maximum (the flat-top amplitude), and emits one event per pulse: amplitude, timestamp of the maximum, and time-over-threshold. Events go to the readout side through a one-entry valid/ready output register, with a saturating drop counter.

## Interface
- DATA_W, 16: width of the signed filter sample.
- TS_W, 32: timestamp counter width.
- THRESHOLD, 100: signed trigger level, DATA_W bits.
- HOLDOFF, 4: dead cycles after a pulse ends, 0..255.
- WIDTH_W, 8: time-over-threshold field width.

- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- filter_data  in  DATA_W  signed filtered sample, one per clk.
- out_ready  in  1  consumer accepts the event.
- out_valid  out  1  event register holds an unread event.
- peak_value  out  DATA_W  signed pulse maximum.
- peak_time  out  TS_W  timestamp of the maximum.
- peak_width  out  WIDTH_W  samples above threshold, saturating.
- pileup  out  1  peak_width saturated on this event.
- dropped_cnt  out  16  events lost while the output was full, saturating.

## Operation
- ts: free-running counter. It is 0 after reset, increments every clk and wraps at 2^TS_W. The sample taken at an edge carries the ts value current at that edge.
- All comparisons are signed and strict: a sample is above threshold when filter_data > THRESHOLD.
- IDLE
  - Above-threshold sample: load max=sample, max_ts=ts, width=1, then go to RISE.
  - Otherwise stay in IDLE.
- RISE
  - Above-threshold sample: increment width, saturating at 2^WIDTH_W-1.
  - If the sample is strictly greater than max, update max and max_ts. Ties keep the earliest time.
  - Sample at or below threshold: emit the event (max, max_ts, width, pileup = width saturated). This sample is not counted.
  - After emitting, go to HOLD with cnt=HOLDOFF, or straight to IDLE if HOLDOFF=0.
- HOLD
  - Input is ignored; cnt decrements each clk.
  - Go to IDLE on the edge where cnt reaches 1 → 0. The dead time is exactly HOLDOFF samples.
- Emit rule
  - The event is loaded into the output register when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle. The latter is a simultaneous pop and push, with no bubble.
  - Otherwise the event is discarded and dropped_cnt increments, saturating at 65535.
- Output register: out_valid clears on the edge where out_valid=1 and out_ready=1 with no new load. Contents are stable while out_valid=1 and out_ready=0.
- Reset (reset=0 at an edge)
  - State goes to IDLE; ts, max, width and cnt clear.
  - out_valid=0; peak_value, peak_time, peak_width, pileup and dropped_cnt all 0.
  - An in-progress pulse is discarded.
  - Reset wins over every other event in the same cycle.

## Timing
- Latency: out_valid rises on the edge that samples the first at-or-below-threshold value, i.e. 1 clk after that sample is presented.
- Throughput: at most one event per (width + 1 + HOLDOFF) clks.
- out_ready is sampled at the edge; no combinational path runs from out_ready to out_valid.
- All outputs are registered.

## Test plan
- **Basic pulse.** Reset, then filter_data=0 until ts=10, then 50,150,300,420,420,380,90 at ts 10..16. Required: out_valid after edge ts=16, peak_value=420, peak_time=13, peak_width=5, pileup=0.
- **Holdoff.** Basic pulse, then 200 at ts 17..20 and 0 afterwards. Required: no second event (HOLDOFF=4). Repeating with 200 at ts 21 gives an event with peak_time=21, peak_width=1.
- **Backpressure.** out_ready=0 across two separated pulses (peaks 300, then 500). Required: first event held stable, dropped_cnt=1. Then assert out_ready: out_valid falls the next edge.
- **Simultaneous pop and push.** out_ready=1 on exactly the edge a new event emits. Required: new event loaded, out_valid stays 1, dropped_cnt unchanged.
- **Pile-up and sign.** filter_data=-32768 for 20 clks gives no event. Then 1000 for 300 clks, then 0. Required: peak_width=255, pileup=1, peak_time equal to the first 1000 sample's ts.
- **Reset mid-pulse.** Drive 300 for 3 clks, pulse reset low for 1 clk, then 0. Required: no event, all outputs 0, ts restarts at 0.
- **Timestamp wrap.** TS_W=8, pulse peak at ts=255 then falling. Required: peak_time=255, and the following ts wraps to 0.
